memwb_elastic: RTL and testbench

Parametrised, elastic successor to the fixed MEM/WB latch. It carries one control field and one data field per beat from the memory stage to the writeback stage using a valid/ready handshake. It supports back-pressure through an optional two-entry skid buffer, and a flush that turns in-flight beats into bubbles. Bubbles always present a zeroed control field, so writeback never commits a register write for an invalid beat.

---
 rtl/memwb_elastic.sv | 78 +++++++
 tb/tb_memwb_elastic.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/memwb_elastic.sv
// MEM/WB elastic pipeline register with optional two-entry skid buffer.
// Bubbles always present a zeroed control field to writeback.
module memwb_elastic #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 197,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iValid,
  output logic              oReady,
  input  logic [CTRL_W-1:0] iCtrl,
  input  logic [DATA_W-1:0] iData,
  input  logic              iFlush,
  output logic              oValid,
  input  logic              iReady,
  output logic [CTRL_W-1:0] oCtrl,
  output logic [DATA_W-1:0] oData,
  output logic [1:0]        oCount
);

  logic              mv;
  logic              sv;
  logic [CTRL_W-1:0] mCtrl;
  logic [CTRL_W-1:0] sCtrl;
  logic [DATA_W-1:0] mData;
  logic [DATA_W-1:0] sData;
  logic              accept;
  logic              pop;

  assign oReady = (SKID != 0) ? !sv : (!mv || iReady);
  assign pop    = mv && iReady;
  assign accept = iValid && oReady;

  assign oValid = mv;
  assign oCtrl  = mCtrl;
  assign oData  = mData;
  assign oCount = {1'b0, mv} + {1'b0, sv};

  // Stored ctrl is cleared whenever its entry goes invalid,
  // so oCtrl needs no output gating.
  always_ff @(posedge clk) begin
    if (rst) begin
      mv    <= 1'b0;
      sv    <= 1'b0;
      mCtrl <= '0;
      sCtrl <= '0;
      mData <= '0;
      sData <= '0;
    end else if (iFlush) begin
      mv    <= 1'b0;
      sv    <= 1'b0;
      mCtrl <= '0;
      sCtrl <= '0;
    end else if (pop && sv) begin
      mCtrl <= sCtrl;
      mData <= sData;
      sv    <= 1'b0;
      sCtrl <= '0;
    end else if (pop && accept) begin
      mCtrl <= iCtrl;
      mData <= iData;
      mv    <= 1'b1;
    end else if (pop) begin
      mv    <= 1'b0;
      mCtrl <= '0;
    end else if (accept && !mv) begin
      mCtrl <= iCtrl;
      mData <= iData;
      mv    <= 1'b1;
    end else if (accept && (SKID != 0)) begin
      sCtrl <= iCtrl;
      sData <= iData;
      sv    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memwb_elastic.sv
// Bench for memwb_elastic: SKID=1 and SKID=0 instances share stimulus,
// each checked against a FIFO-of-beats reference model.
module tb_memwb_elastic;

  localparam int CW = 5;
  localparam int DW = 197;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iValid = 1'b0;
  logic [CW-1:0] iCtrl = '0;
  logic [DW-1:0] iData = '0;
  logic          iFlush = 1'b0;
  logic          iReady = 1'b0;

  logic          aReady, aValid, bReady, bValid;
  logic [CW-1:0] aCtrl, bCtrl;
  logic [DW-1:0] aData, bData;
  logic [1:0]    aCount, bCount;

  int nCmp = 0;
  int nFail = 0;
  bit armed = 1'b0;

  // model: per instance, ordered beats held (slot 0 = head)
  int            cnt [2];
  logic [CW-1:0] mc [2][2];
  logic [DW-1:0] md [2][2];
  logic [DW-1:0] lastD [2];

  always #5 clk = ~clk;

  memwb_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dutA (
    .clk(clk), .rst(rst), .iValid(iValid), .oReady(aReady),
    .iCtrl(iCtrl), .iData(iData), .iFlush(iFlush),
    .oValid(aValid), .iReady(iReady), .oCtrl(aCtrl),
    .oData(aData), .oCount(aCount)
  );

  memwb_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dutB (
    .clk(clk), .rst(rst), .iValid(iValid), .oReady(bReady),
    .iCtrl(iCtrl), .iData(iData), .iFlush(iFlush),
    .oValid(bValid), .iReady(iReady), .oCtrl(bCtrl),
    .oData(bData), .oCount(bCount)
  );

  function automatic bit mReady(int d);
    if (d == 0) return cnt[0] < 2;
    return (cnt[1] == 0) || iReady;
  endfunction

  task automatic modelEdge();
    for (int d = 0; d < 2; d++) begin
      bit popB;
      bit accB;
      popB = (cnt[d] > 0) && iReady;
      accB = iValid && mReady(d);
      if (rst) begin
        cnt[d] = 0;
        lastD[d] = '0;
      end else if (iFlush) begin
        cnt[d] = 0;
      end else begin
        if (popB) begin
          mc[d][0] = mc[d][1];
          md[d][0] = md[d][1];
          cnt[d] = cnt[d] - 1;
        end
        if (accB) begin
          mc[d][cnt[d]] = iCtrl;
          md[d][cnt[d]] = iData;
          cnt[d] = cnt[d] + 1;
        end
        if (cnt[d] > 0) lastD[d] = md[d][0];
      end
    end
  endtask

  task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    nCmp++;
    assert (got === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chkOut();
    chk("A.oValid", DW'(aValid), DW'(cnt[0] > 0));
    chk("A.oCtrl", DW'(aCtrl), cnt[0] > 0 ? DW'(mc[0][0]) : '0);
    chk("A.oData", aData, lastD[0]);
    chk("A.oCount", DW'(aCount), DW'(cnt[0]));
    chk("B.oValid", DW'(bValid), DW'(cnt[1] > 0));
    chk("B.oCtrl", DW'(bCtrl), cnt[1] > 0 ? DW'(mc[1][0]) : '0);
    chk("B.oData", bData, lastD[1]);
    chk("B.oCount", DW'(bCount), DW'(cnt[1]));
  endtask

  // inputs are already set; check ready before the edge, state after it
  task automatic cyc();
    #1;
    if (armed) begin
      chk("A.oReady", DW'(aReady), DW'(mReady(0)));
      chk("B.oReady", DW'(bReady), DW'(mReady(1)));
    end
    @(posedge clk);
    modelEdge();
    #1;
    chkOut();
    armed = 1'b1;
  endtask

  task automatic drive(bit v, logic [CW-1:0] c, int dat, bit rdy, bit fl);
    iValid = v;
    iCtrl  = c;
    iData  = DW'(dat);
    iReady = rdy;
    iFlush = fl;
    cyc();
  endtask

  initial begin
    logic [223:0] wide;
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0;
      lastD[d] = '0;
    end
    // reset, then stream 1..8
    rst = 1'b1;
    drive(0, '0, 0, 0, 0);
    drive(1, 5'h1F, 99, 1, 1);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) drive(1, 5'h1F, i, 1, 0);
    drive(0, '0, 0, 1, 0);
    // stall with skid
    drive(1, 5'h1F, 10, 1, 0);
    drive(1, 5'h1F, 11, 0, 0);
    drive(1, 5'h1F, 12, 0, 0);
    drive(1, 5'h1F, 12, 0, 0);
    drive(1, 5'h1F, 12, 1, 0);
    drive(1, 5'h1F, 12, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, '0, 0, 1, 0);
    // flush with both entries held
    drive(1, 5'h1F, 20, 0, 0);
    drive(1, 5'h1F, 21, 0, 0);
    drive(1, 5'h1F, 22, 0, 1);
    drive(0, '0, 0, 1, 0);
    drive(0, '0, 0, 1, 0);
    // bubble gating
    drive(1, 5'b10110, 30, 0, 0);
    drive(0, '0, 0, 1, 0);
    drive(0, '0, 0, 1, 0);
    // combinational ready for SKID=0
    drive(1, 5'h03, 40, 0, 0);
    drive(1, 5'h03, 41, 0, 0);
    drive(1, 5'h03, 41, 1, 0);
    drive(0, '0, 0, 1, 0);
    // reset mid-operation with flush asserted
    drive(1, 5'h07, 50, 0, 0);
    drive(1, 5'h07, 51, 0, 0);
    rst = 1'b1;
    drive(1, 5'h07, 52, 0, 1);
    rst = 1'b0;
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 7; k++) wide[k*32 +: 32] = $urandom;
      rst    = ($urandom_range(0, 63) == 0);
      iValid = $urandom_range(0, 3) != 0;
      iCtrl  = CW'($urandom);
      iData  = wide[DW-1:0];
      iReady = $urandom_range(0, 2) != 0;
      iFlush = ($urandom_range(0, 15) == 0);
      cyc();
    end
    rst = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
